// File: rtl/ubus_monitor.sv
// DC-bus voltage monitor: periodic ADC trigger, boxcar average over 2^AVG_LOG2 samples,
// OV/UV flags with hysteresis and sticky conversion timeout. Optional prefilter: UBUS_MEDIAN3_EN.
//
// state | meaning
// IDLE  | wait for period tick
// TRIG  | oAcquire_en high for one cycle
// WAIT  | wait for iAdc_done rising edge or timeout
// MED   | median-of-3 prefilter on raw sample (UBUS_MEDIAN3_EN only)
// ACC   | write sample into window, update running sum
// OUT   | publish average and flags once the window is full
module ubus_monitor #(
  parameter int unsigned SAMPLE_PERIOD = 10000,
  parameter int unsigned AVG_LOG2      = 3,
  parameter int unsigned TIMEOUT_CYC   = 1024,
  parameter int unsigned OV_THRESH     = 3500,
  parameter int unsigned UV_THRESH     = 1000,
  parameter int unsigned HYST          = 50
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iEnable,
  input  logic [11:0] iAdc_data,
  input  logic        iAdc_done,
  output logic        oAcquire_en,
  output logic [11:0] oUbus_avg,
  output logic        oValid,
  output logic        oOver_voltage,
  output logic        oUnder_voltage,
  output logic        oTimeout_err
);

  localparam int          DEPTH     = 1 << AVG_LOG2;
  localparam int unsigned AW        = 12 + AVG_LOG2;
  localparam int unsigned FW        = AVG_LOG2 + 1;
  localparam int unsigned TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [15:0]   PER_LOAD  = 16'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYC - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
  localparam logic [11:0]   OV_SET    = 12'(OV_THRESH);
  localparam logic [11:0]   OV_CLR    = 12'(OV_THRESH - HYST);
  localparam logic [11:0]   UV_SET    = 12'(UV_THRESH);
  localparam logic [11:0]   UV_CLR    = 12'(UV_THRESH + HYST);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT, MED, ACC, OUT} state_t;

  state_t              state;
  logic [15:0]         perCnt;
  logic [TW-1:0]       toCnt;
  logic                doneQ;
  logic [11:0]         sample;
  logic [11:0]         winBuf [DEPTH];
  logic [AVG_LOG2-1:0] wrPtr;
  logic [FW-1:0]       fill;
  logic [AW-1:0]       acc;

  logic                tick;
  logic                doneRise;
  logic [11:0]         oldest;
  logic [AW:0]         accSum;
  logic [11:0]         newAvg;

  // Period counter counts down; count 0 is the tick and also the value held while disabled,
  // so the first enabled cycle always triggers.
  assign tick     = iEnable && (perCnt == 16'd0);
  assign doneRise = iAdc_done && !doneQ;
  assign oldest   = (fill == FILL_FULL) ? winBuf[wrPtr] : 12'd0;
  assign accSum   = {1'b0, acc} + {{(AVG_LOG2 + 1){1'b0}}, sample}
                                - {{(AVG_LOG2 + 1){1'b0}}, oldest};
  assign newAvg   = acc[AW-1:AVG_LOG2];

`ifdef UBUS_MEDIAN3_EN
  logic [11:0] hist0;
  logic [11:0] hist1;
  logic [1:0]  medCnt;

  function automatic logic [11:0] med3(input logic [11:0] a, input logic [11:0] b,
                                       input logic [11:0] c);
    logic [11:0] lo;
    logic [11:0] hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (c < lo) ? lo : ((c > hi) ? hi : c);
  endfunction
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state          <= IDLE;
      perCnt         <= '0;
      toCnt          <= '0;
      doneQ          <= 1'b0;
      sample         <= '0;
      wrPtr          <= '0;
      fill           <= '0;
      acc            <= '0;
      for (int i = 0; i < DEPTH; i++) winBuf[i] <= '0;
      oAcquire_en    <= 1'b0;
      oUbus_avg      <= '0;
      oValid         <= 1'b0;
      oOver_voltage  <= 1'b0;
      oUnder_voltage <= 1'b0;
      oTimeout_err   <= 1'b0;
`ifdef UBUS_MEDIAN3_EN
      hist0          <= '0;
      hist1          <= '0;
      medCnt         <= '0;
`endif
    end else begin
      doneQ       <= iAdc_done;
      oValid      <= 1'b0;
      oAcquire_en <= 1'b0;
      if (!iEnable) begin
        state          <= IDLE;
        perCnt         <= '0;
        toCnt          <= '0;
        wrPtr          <= '0;
        fill           <= '0;
        acc            <= '0;
        for (int i = 0; i < DEPTH; i++) winBuf[i] <= '0;
        oOver_voltage  <= 1'b0;
        oUnder_voltage <= 1'b0;
        oTimeout_err   <= 1'b0;
`ifdef UBUS_MEDIAN3_EN
        medCnt         <= '0;
`endif
      end else begin
        perCnt <= (perCnt == 16'd0) ? PER_LOAD : perCnt - 16'd1;
        case (state)
          IDLE: begin
            if (tick) begin
              state       <= TRIG;
              oAcquire_en <= 1'b1;
            end
          end
          TRIG: begin
            state <= WAIT;
            toCnt <= TO_LOAD;
          end
          WAIT: begin
            if (doneRise) begin
              sample <= iAdc_data;
`ifdef UBUS_MEDIAN3_EN
              state  <= MED;
`else
              state  <= ACC;
`endif
            end else if (toCnt == '0) begin
              oTimeout_err <= 1'b1;
              state        <= IDLE;
            end else begin
              toCnt <= toCnt - 1'b1;
            end
          end
`ifdef UBUS_MEDIAN3_EN
          MED: begin
            if (medCnt == 2'd2) sample <= med3(hist1, hist0, sample);
            else                medCnt <= medCnt + 2'd1;
            hist1 <= hist0;
            hist0 <= sample;
            state <= ACC;
          end
`endif
          ACC: begin
            winBuf[wrPtr] <= sample;
            acc           <= accSum[AW-1:0];
            wrPtr         <= wrPtr + 1'b1;
            if (fill != FILL_FULL) fill <= fill + 1'b1;
            state         <= OUT;
          end
          OUT: begin
            if (fill == FILL_FULL) begin
              oUbus_avg <= newAvg;
              oValid    <= 1'b1;
              if (newAvg > OV_SET)      oOver_voltage <= 1'b1;
              else if (newAvg < OV_CLR) oOver_voltage <= 1'b0;
              if (newAvg < UV_SET)      oUnder_voltage <= 1'b1;
              else if (newAvg > UV_CLR) oUnder_voltage <= 1'b0;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ubus_monitor.sv
// Bench for ubus_monitor: hand-computed flag/hysteresis vectors plus randomized samples
// checked against a sliding-window reference model.
module tb_ubus_monitor;

  localparam int PERIOD = 400;
  localparam int TOUT   = 360;
`ifdef UBUS_MEDIAN3_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iEnable = 1'b0;
  logic [11:0] iAdc_data = 12'd0;
  logic        iAdc_done = 1'b0;
  logic        oAcquire_en;
  logic [11:0] oUbus_avg;
  logic        oValid;
  logic        oOver_voltage;
  logic        oUnder_voltage;
  logic        oTimeout_err;

  int          checks = 0;
  int          failures = 0;
  longint      cyc = 0;
  longint      prevTrig = -1;
  longint      enCyc = 0;
  bit          firstAfterEn = 0;
  bit          expErr = 0;
  logic [11:0] lastAvg = 12'd0;

  // reference model state
  int          win[$];
  int          raw[$];
  bit          mOv = 0;
  bit          mUv = 0;

  typedef struct {
    logic [11:0] val;
    bit          v;
    logic [11:0] avg;
    bit          ov;
    bit          uv;
  } vec_t;
  vec_t tbl[$];

  ubus_monitor #(
    .SAMPLE_PERIOD(PERIOD), .AVG_LOG2(3), .TIMEOUT_CYC(TOUT),
    .OV_THRESH(3500), .UV_THRESH(1000), .HYST(50)
  ) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iEnable(iEnable),
    .iAdc_data(iAdc_data), .iAdc_done(iAdc_done),
    .oAcquire_en(oAcquire_en), .oUbus_avg(oUbus_avg), .oValid(oValid),
    .oOver_voltage(oOver_voltage), .oUnder_voltage(oUnder_voltage),
    .oTimeout_err(oTimeout_err)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  function automatic void addVec(input int val, input bit v, input int avg,
                                 input bit ov, input bit uv);
    vec_t e;
    e.val = 12'(val); e.v = v; e.avg = 12'(avg); e.ov = ov; e.uv = uv;
    tbl.push_back(e);
  endfunction

  function automatic void modelReset();
    win.delete(); raw.delete(); mOv = 0; mUv = 0;
  endfunction

  task automatic modelPush(input int s, output bit v, output int avg);
    int f;
    int t[$];
    f = s;
`ifdef UBUS_MEDIAN3_EN
    if (raw.size() >= 2) begin
      t = {raw[raw.size()-2], raw[raw.size()-1], s};
      t.sort();
      f = t[1];
    end
`endif
    raw.push_back(s);
    if (raw.size() > 3) void'(raw.pop_front());
    win.push_back(f);
    if (win.size() > 8) void'(win.pop_front());
    v = (win.size() == 8);
    avg = v ? (win.sum() / 8) : 0;
    if (v) begin
      if (avg > 3500) mOv = 1; else if (avg < 3450) mOv = 0;
      if (avg < 1000) mUv = 1; else if (avg > 1050) mUv = 0;
    end
  endtask

  task automatic enableOn();
    iEnable = 1'b1;
    enCyc = cyc;
    firstAfterEn = 1;
    prevTrig = -1;
  endtask

  task automatic disableChk(input string tag);
    iEnable = 1'b0;
    step();
    check({tag, "_dis_acq"}, oAcquire_en, 0);
    check({tag, "_dis_valid"}, oValid, 0);
    check({tag, "_dis_ov"}, oOver_voltage, 0);
    check({tag, "_dis_uv"}, oUnder_voltage, 0);
    check({tag, "_dis_err"}, oTimeout_err, 0);
    check({tag, "_dis_avg_hold"}, oUbus_avg, lastAvg);
    expErr = 0;
    modelReset();
  endtask

  // Finds the next trigger; returns one cycle after the trigger, with the DUT in WAIT.
  task automatic waitTrig(output bit ok);
    bit sawV;
    ok = 0; sawV = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      step();
      sawV |= oValid;
      if (oAcquire_en) begin ok = 1; break; end
    end
    check("no_valid_before_trigger", sawV, 0);
    if (!ok) begin
      check("trigger_seen", 0, 1);
    end else begin
      if (firstAfterEn) check("first_trigger_latency", 32'(cyc - enCyc), 1);
      else if (prevTrig >= 0) check("trigger_period", 32'(cyc - prevTrig), PERIOD);
      firstAfterEn = 0;
      prevTrig = cyc;
      step();
      check("acq_pulse_width", oAcquire_en, 0);
    end
  endtask

  task automatic convert(input logic [11:0] val, input int dly, input bit expValid,
                         input logic [11:0] expAvg, input bit expOv, input bit expUv,
                         input string tag);
    bit ok;
    bit sawV;
    waitTrig(ok);
    if (!ok) return;
    sawV = 0;
    repeat (dly) begin step(); sawV |= oValid; end
    iAdc_data = val;
    iAdc_done = 1'b1;
    for (int k = 1; k < LAT; k++) begin step(); sawV |= oValid; end
    check({tag, "_early_valid"}, sawV, 0);
    step();
    check({tag, "_valid"}, oValid, expValid);
    if (expValid) lastAvg = expAvg;
    check({tag, "_avg"}, oUbus_avg, lastAvg);
    check({tag, "_ov"}, oOver_voltage, expOv);
    check({tag, "_uv"}, oUnder_voltage, expUv);
    check({tag, "_err"}, oTimeout_err, expErr);
    step();
    check({tag, "_valid_width"}, oValid, 0);
    step();
    iAdc_done = 1'b0;
    iAdc_data = 12'($urandom_range(0, 4095));
  endtask

  task automatic modelConvert(input int s, input int dly, input string tag);
    bit v;
    int avg;
    modelPush(s, v, avg);
    convert(12'(s), dly, v, 12'(avg), mOv, mUv, tag);
  endtask

  task automatic timeoutRun();
    bit ok;
    bit sawV;
    waitTrig(ok);
    if (!ok) return;
    sawV = 0;
    for (int n = 2; n <= TOUT + 1; n++) begin
      step();
      sawV |= oValid;
      if (n == TOUT - 1) check("timeout_err_not_early", oTimeout_err, 0);
    end
    check("timeout_err_set", oTimeout_err, 1);
    check("timeout_no_valid", sawV, 0);
    expErr = 1;
  endtask

  function automatic int noisy(input int base);
    int s;
    s = base + int'($urandom_range(0, 160)) - 80;
    if (s < 0) s = 0;
    if (s > 4095) s = 4095;
    return s;
  endfunction

  initial begin
    bit ok;
    bit sawV;
    bit sawA;
    int base;

`ifdef UBUS_MEDIAN3_EN
    // spike at sample 3 is rejected by the median, window fills with 2000
    addVec(2000, 0, 0, 0, 0); addVec(2000, 0, 0, 0, 0); addVec(4095, 0, 0, 0, 0);
    addVec(2000, 0, 0, 0, 0); addVec(2000, 0, 0, 0, 0); addVec(2000, 0, 0, 0, 0);
    addVec(2000, 0, 0, 0, 0); addVec(2000, 1, 2000, 0, 0);
`else
    for (int i = 0; i < 7; i++) addVec(2000, 0, 0, 0, 0);
    addVec(2000, 1, 2000, 0, 0);
    // over-voltage ramp: set on first average above 3500
    addVec(3400, 1, 2175, 0, 0);
    addVec(3600, 1, 2375, 0, 0); addVec(3600, 1, 2575, 0, 0); addVec(3600, 1, 2775, 0, 0);
    addVec(3600, 1, 2975, 0, 0); addVec(3600, 1, 3175, 0, 0); addVec(3600, 1, 3375, 0, 0);
    addVec(3600, 1, 3575, 1, 0); addVec(3600, 1, 3600, 1, 0);
    // 3460: inside hysteresis band, flag held
    addVec(3460, 1, 3582, 1, 0); addVec(3460, 1, 3565, 1, 0); addVec(3460, 1, 3547, 1, 0);
    addVec(3460, 1, 3530, 1, 0); addVec(3460, 1, 3512, 1, 0); addVec(3460, 1, 3495, 1, 0);
    addVec(3460, 1, 3477, 1, 0); addVec(3460, 1, 3460, 1, 0);
    // 3440: clears once average drops below 3450
    addVec(3440, 1, 3457, 1, 0); addVec(3440, 1, 3455, 1, 0); addVec(3440, 1, 3452, 1, 0);
    addVec(3440, 1, 3450, 1, 0); addVec(3440, 1, 3447, 0, 0); addVec(3440, 1, 3445, 0, 0);
    addVec(3440, 1, 3442, 0, 0); addVec(3440, 1, 3440, 0, 0);
    // under-voltage set below 1000
    addVec(900, 1, 3122, 0, 0); addVec(900, 1, 2805, 0, 0); addVec(900, 1, 2487, 0, 0);
    addVec(900, 1, 2170, 0, 0); addVec(900, 1, 1852, 0, 0); addVec(900, 1, 1535, 0, 0);
    addVec(900, 1, 1217, 0, 0); addVec(900, 1, 900, 0, 1);
    // 1060: held until average exceeds 1050
    addVec(1060, 1, 920, 0, 1); addVec(1060, 1, 940, 0, 1); addVec(1060, 1, 960, 0, 1);
    addVec(1060, 1, 980, 0, 1); addVec(1060, 1, 1000, 0, 1); addVec(1060, 1, 1020, 0, 1);
    addVec(1060, 1, 1040, 0, 1); addVec(1060, 1, 1060, 0, 0);
`endif

    iRst_n = 1'b0;
    repeat (3) step();
    check("rst_acq", oAcquire_en, 0);
    check("rst_avg", oUbus_avg, 0);
    check("rst_valid", oValid, 0);
    check("rst_ov", oOver_voltage, 0);
    check("rst_uv", oUnder_voltage, 0);
    check("rst_err", oTimeout_err, 0);
    iRst_n = 1'b1;
    sawA = 0;
    repeat (20) begin step(); sawA |= oAcquire_en; end
    check("no_trigger_while_disabled", sawA, 0);

    enableOn();
    for (int i = 0; i < tbl.size(); i++)
      convert(tbl[i].val, (i < 8) ? 320 : int'($urandom_range(0, 330)), tbl[i].v,
              tbl[i].avg, tbl[i].ov, tbl[i].uv, $sformatf("vec%0d", i));

    disableChk("after_vec");
    repeat (10) step();
    enableOn();

    base = 2000;
    for (int i = 0; i < 10; i++) begin
      if (i % 4 == 0) base = int'($urandom_range(0, 4095));
      modelConvert(noisy(base), int'($urandom_range(0, 330)), $sformatf("rnd%0d", i));
    end
    timeoutRun();
    for (int i = 0; i < 6; i++) begin
      if (i % 3 == 0) base = int'($urandom_range(0, 4095));
      modelConvert(noisy(base), int'($urandom_range(0, 330)), $sformatf("post_to%0d", i));
    end

    // disable mid-conversion, stale done while idle must not be captured
    waitTrig(ok);
    repeat (100) step();
    disableChk("midwait");
    sawV = 0;
    repeat (19) begin step(); sawV |= oValid; end
    iAdc_data = 12'd4000;
    iAdc_done = 1'b1;
    repeat (5) begin step(); sawV |= oValid; end
    iAdc_done = 1'b0;
    repeat (25) begin step(); sawV |= oValid; end
    check("stale_done_ignored", sawV, 0);
    enableOn();
    base = int'($urandom_range(0, 4095));
    for (int i = 0; i < 8; i++)
      modelConvert(noisy(base), int'($urandom_range(0, 330)), $sformatf("refill%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
